mul_arbiter: RTL and testbench

Sequencer and two-port round-robin arbiter for the shared 32×32 signed array multiplier (`MULarray`). It accepts operand pairs from two requesters over valid/ready handshakes and registers them into one `MULarray` instance. The multiplier is given a fixed multicycle settle window, after which the block captures the 64-bit product and returns it with the source ID over a back-pressurable response port. It sits between the execute-stage requesters and the multiplier so that a single array is shared instead of duplicated.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_arbiter_array.sv | 23 ++
 rtl/mul_arbiter.sv | 112 +++++++++++
 tb/tb_mul_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiplier sequencer/arbiter.
//   state_t  - sequencer states (IDLE, CALC, RESP)
//   src_t    - requester ID carried with each product
//   MUL_WIDTH / MUL_SETTLE - default operand width and settle window
package mul_pkg;

    localparam int MUL_WIDTH  = 32;
    localparam int MUL_SETTLE = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic src_t;

endpackage

// File: rtl/mul_arbiter_array.sv
// MULarray: combinational WIDTH x WIDTH signed multiplier.
//   a, x : signed operands (WIDTH bits)
//   p    : full two's-complement product (2*WIDTH bits)
// The result needs several cycles to settle in silicon; the sequencer
// holds the operands stable and waits before sampling p.
module MULarray #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   x,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_x_ext;

    // Sign-extend to the product width so the low 2*WIDTH bits of the
    // unsigned product equal the signed product.
    assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_x_ext = {{WIDTH{x[WIDTH-1]}}, x};
    assign p       = w_a_ext * w_x_ext;

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: two-port round-robin arbiter and sequencer for one shared
// MULarray. A granted operand pair is registered, the array is given
// SETTLE cycles, then the product is captured and offered on a
// back-pressurable response port together with the source ID.
//   clk, rst_n             - clock, synchronous active-low reset
//   reqN_valid/ready/a/x   - requester N operand handshake (N = 0, 1)
//   resp_valid/ready       - product handshake
//   resp_p, resp_src       - signed product and issuing requester
//   busy                   - high whenever not IDLE
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int WIDTH  = MUL_WIDTH,
    parameter int SETTLE = MUL_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_x,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_x,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [2*WIDTH-1:0] resp_p,
    output logic               resp_src,
    output logic               busy
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             r_state;
    src_t               r_last;
    src_t               r_src;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_x;
    logic [2*WIDTH-1:0] r_p;

    logic               w_idle;
    src_t               w_grant;
    logic               w_hs;
    logic [2*WIDTH-1:0] w_p;

    // Ready is also gated by reset so nothing looks accepted while the
    // block is being held in reset.
    assign w_idle  = rst_n && (r_state == ST_IDLE);

    // On a tie the requester not served last wins; otherwise whoever is
    // valid. With nobody valid the grant value is irrelevant.
    assign w_grant = (req0_valid && req1_valid) ? ~r_last : req1_valid;

    assign req0_ready = w_idle && req0_valid && (w_grant == 1'b0);
    assign req1_ready = w_idle && req1_valid && (w_grant == 1'b1);
    assign w_hs       = req0_ready || req1_ready;

    MULarray #(.WIDTH(WIDTH)) u_mul (
        .a (r_a),
        .x (r_x),
        .p (w_p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_src   <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_x     <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_a     <= w_grant ? req1_a : req0_a;
                        r_x     <= w_grant ? req1_x : req0_x;
                        r_src   <= w_grant;
                        r_cnt   <= CW'(SETTLE - 1);
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == '0) begin
                        r_p     <= w_p;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    // The response handshake cycle never accepts a new
                    // request; arbitration resumes in the next IDLE cycle.
                    if (resp_ready) begin
                        r_last  <= r_src;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_p     = r_p;
    assign resp_src   = r_src;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

    localparam int W      = 32;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_x, req1_a, req1_x;
    logic          resp_valid, resp_ready, resp_src, busy;
    logic [2*W-1:0] resp_p;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase flags plus a cycle countdown to the result.
    bit      m_calc, m_resp;
    int      m_left;
    bit      m_last;
    bit      m_src;
    longint  m_pend, m_p;
    int      n_resp = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_x     (req0_x),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_x     (req1_x),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .resp_src   (resp_src),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint smul(input logic [W-1:0] a, input logic [W-1:0] x);
        longint sa, sx;
        sa = longint'($signed(a));
        sx = longint'($signed(x));
        return sa * sx;
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model,
    // then advance the model to what the coming edge should produce.
    task automatic step(input bit rst, input bit v0, input logic [W-1:0] a0, input logic [W-1:0] x0,
                        input bit v1, input logic [W-1:0] a1, input logic [W-1:0] x1, input bit rr);
        bit e0, e1, idle;
        @(posedge clk);
        #1;
        rst_n = rst; req0_valid = v0; req0_a = a0; req0_x = x0;
        req1_valid = v1; req1_a = a1; req1_x = x1; resp_ready = rr;
        #1;
        idle = rst && !m_calc && !m_resp;
        e0 = idle && v0 && (!v1 || m_last);
        e1 = idle && v1 && (!v0 || !m_last);
        chk("ready", {62'd0, req1_ready, req0_ready}, {62'd0, e1, e0});
        chk("vld_busy", {62'd0, resp_valid, busy}, {62'd0, m_resp, m_calc || m_resp});
        chk("prod", resp_p, m_p);
        chk("src", {63'd0, resp_src}, {63'd0, m_src});
        if (!rst) begin
            m_calc = 0; m_resp = 0; m_left = 0; m_last = 1; m_p = 0; m_src = 0;
        end else if (m_resp) begin
            if (rr) begin m_last = m_src; m_resp = 0; n_resp++; end
        end else if (m_calc) begin
            m_left--;
            if (m_left == 0) begin m_calc = 0; m_resp = 1; m_p = m_pend; end
        end else if (e0 || e1) begin
            m_src  = e1;
            m_pend = e1 ? smul(a1, x1) : smul(a0, x0);
            m_calc = 1;
            m_left = SETTLE;
        end
    endtask

    task automatic idle_cyc(input bit rr);
        step(1, 0, '0, '0, 0, '0, '0, rr);
    endtask

    // Single operation from requester 0 with fixed latency and a constant
    // expected product checked in the first response cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] x, input logic [63:0] exp);
        step(1, 1, a, x, 0, '0, '0, 1);
        for (int i = 0; i < SETTLE; i++) step(1, 0, $urandom, $urandom, 0, '0, '0, 1);
        step(1, 0, '0, '0, 0, '0, '0, 1);
        chk("lat_valid", {63'd0, resp_valid}, 64'd1);
        chk("const_p", resp_p, exp);
        chk("const_src", {63'd0, resp_src}, 64'd0);
    endtask

    initial begin
        rst_n = 0; req0_valid = 1; req1_valid = 1; resp_ready = 0;
        req0_a = '0; req0_x = '0; req1_a = '0; req1_x = '0;
        m_calc = 0; m_resp = 0; m_left = 0; m_last = 1; m_p = 0; m_src = 0; m_pend = 0;

        // Reset held three cycles with both requesters asking.
        for (int i = 0; i < 3; i++) step(0, 1, 32'd7, 32'd9, 1, 32'd5, 32'd3, 1);
        // First cycle after release: requester 0 wins the tie.
        step(1, 1, 32'd7, 32'd9, 1, 32'd5, 32'd3, 1);
        chk("first_tie", {62'd0, req1_ready, req0_ready}, 64'd1);
        for (int i = 0; i < 4; i++) idle_cyc(1);

        do_op(32'd4, 32'd4, 64'd16);
        idle_cyc(1);
        do_op(32'd2, -32'sd20, -64'sd40);
        do_op(-32'sd3, -32'sd30, 64'd90);
        do_op(32'hffff8000, 32'h07830002, 64'hFFFFFC3E7FFF0000);
        idle_cyc(1);

        // Continuous contention; backpressure window of five cycles.
        for (int i = 0; i < 24; i++)
            step(1, 1, 32'(100 + i), 32'd3, 1, 32'(200 + i), -32'sd5, !(i >= 3 && i < 8));
        for (int i = 0; i < 4; i++) idle_cyc(1);

        // Reset during CALC: the operation must vanish.
        step(1, 1, 32'd11, 32'd13, 0, '0, '0, 1);
        step(0, 0, '0, '0, 0, '0, '0, 1);
        for (int i = 0; i < 6; i++) idle_cyc(1);

        // req1 pulses while busy, then withdraws.
        step(1, 1, 32'd6, 32'd7, 0, '0, '0, 1);
        step(1, 0, '0, '0, 1, 32'd99, 32'd99, 1);
        step(1, 0, '0, '0, 0, 32'd99, 32'd99, 1);
        for (int i = 0; i < 4; i++) idle_cyc(1);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(99) != 0), $urandom_range(1), $urandom, $urandom,
                 $urandom_range(1), $urandom, $urandom, ($urandom_range(9) < 7));
        for (int i = 0; i < 8; i++) idle_cyc(1);

        chk("resp_seen", {63'd0, n_resp > 20}, 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
